ram_rr_arbiter: RTL and testbench
=================================

Name: ram_rr_arbiter

Overview:
- Shares one single-port synchronous RAM (8 x 8-bit, write on posedge when we=1, read data registered on posedge when we=0) between two requesters, A and B.
- Arbitrates round-robin, sequences each access as issue then response, and returns read data with a one-cycle ack.
- Also provides a clear sequencer that fills every RAM word with a constant.
- Sits between the requesters and the RAM; the RAM is instantiated outside this block.

Parameters:
- AW, 3, address width; RAM depth = 2**AW.
- DW, 8, data width.
- CLR_VALUE, 0, word written to every location during a clear sequence (DW bits).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- a_req  in  1  requester A transaction request.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_ack  out  1  A one-cycle completion pulse.
- a_rdata  out  DW  A read data, valid when a_ack=1 and the transaction was a read.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A ports, for requester B.
- clr_start  in  1  one-cycle pulse that requests a clear sequence.
- busy  out  1  high while the FSM is not in IDLE.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM registered read data.

Behaviour:
- Reset: the clk/rst interface is one clock, synchronous active-high reset.
  - On rst=1 at posedge: state=IDLE; a_ack=b_ack=0; a_rdata=b_rdata=0; ram_we=0; ram_addr=0; ram_din=0; busy=0; last_grant=B (so A wins the first tie); clr_pending=0.
  - Reset mid-transaction or mid-clear abandons it, with no ack.
- States: IDLE, ISSUE, RESP, CLEAR.
- Outputs are registered: ram_we, ram_addr and ram_din are driven from registers set on entry to ISSUE or CLEAR.
- clr_start seen in any state sets clr_pending. clr_pending is cleared on entry to CLEAR.
- IDLE:
  - If clr_pending (or clr_start this cycle), go to CLEAR with clear counter=0. Clear has priority over requests.
  - Else if exactly one req is high, grant it.
  - Else if both are high, grant the requester that is not last_grant.
  - On grant: latch sel, we, addr and wdata into ram_*; set last_grant=sel; go to ISSUE.
  - Else stay in IDLE with ram_we=0.
- ISSUE (one cycle): the RAM performs the write, or registers the read at this posedge. Next state is RESP; ram_we is forced to 0.
- RESP (one cycle):
  - Pulse the selected requester's ack.
  - For a read, load that requester's rdata from ram_dout.
  - For a write, rdata holds its previous value.
  - Next state is always IDLE, so a requester sees its ack before arbitration can reselect it.
- Latency and throughput: req sampled in IDLE at cycle N means ack at cycle N+2. One transaction completes every 3 cycles at most.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - Drop req the cycle after ack, or keep it high to request again.
  - The non-selected requester waits with req high and gets no ack.
- CLEAR:
  - Drive ram_we=1, ram_addr=counter, ram_din=CLR_VALUE for 2**AW consecutive cycles, counter 0 to 2**AW-1, then go to IDLE.
  - No acks are issued during CLEAR; requests wait.
  - clr_start during CLEAR sets clr_pending, so a second full clear follows.
- Clear requested during ISSUE or RESP: the in-flight transaction completes, then the clear starts from IDLE.
- Address wrap: the counter does not wrap past 2**AW-1. Exit from CLEAR occurs at the last address.
- a_ack and b_ack are never high in the same cycle.

Test Plan:
- Reset, then A writes 8'h5A to address 3. Expect ram_we=1, ram_addr=3, ram_din=5A at the ISSUE cycle, and a_ack at req-sample+2. A then reads address 3: a_rdata=8'h5A with a_ack.
- A and B request simultaneously from reset. Expect grant order A, B, A, B over 4 transactions, each ack exactly 3 cycles apart, and never both acks high.
- B requests only. Expect b_ack every 3 cycles while b_req is held, with a_ack staying 0.
- clr_start while idle with CLR_VALUE=0. Expect 8 consecutive cycles with ram_we=1 and addresses 0..7, busy=1 throughout; a subsequent read of address 7 returns 8'h00.
- clr_start pulsed during an A read's ISSUE cycle. Expect the A read to ack with the pre-clear data, then the clear runs; a B request raised during the clear is acked only after the clear finishes.
- rst asserted in the CLEAR state at counter=4. Expect outputs at reset values the next cycle, no further ram_we, busy=0, and no ack.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ram_rr_arbiter
//
// Shares one external single-port synchronous RAM between two requesters (A, B)
// with round-robin arbitration. Each access runs IDLE -> ISSUE -> RESP, so the
// ack arrives two cycles after the request is sampled and a requester sees its
// ack before it can be reselected. A clear sequencer writes CLR_VALUE to every
// RAM word; a clear request always wins over pending accesses.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata requester A request, 1=write, address, write data
//   a_ack, a_rdata           A one-cycle completion pulse, read data
//   b_*                      same as a_* for requester B
//   clr_start                one-cycle pulse requesting a clear sequence
//   busy                     high whenever the sequencer is not idle
//   ram_we/ram_addr/ram_din  registered RAM command
//   ram_dout                 RAM registered read data
// -----------------------------------------------------------------------------
module ram_rr_arbiter #(
  parameter int unsigned     AW        = 3,
  parameter int unsigned     DW        = 8,
  parameter logic [DW-1:0]   CLR_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  input  logic          clr_start,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_CLEAR
  } state_e;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_e        state_q, state_d;
  logic          clr_pending_q, clr_pending_d;
  logic          last_b_q, last_b_d;   // 1: B received the most recent grant
  logic          sel_b_q, sel_b_d;     // requester owning the in-flight access
  logic          txn_we_q, txn_we_d;   // in-flight access is a write
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  logic          clr_req;
  logic          grant_a;
  logic          grant_b;
  logic          pick_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_din;

  // A clear pulse arriving in IDLE is honoured in the same cycle.
  assign clr_req = clr_pending_q | clr_start;

  // On a tie the requester that did not win last time is granted.
  assign grant_a = a_req & (~b_req | last_b_q);
  assign grant_b = b_req & ~grant_a;

  assign pick_we   = grant_b ? b_we    : a_we;
  assign pick_addr = grant_b ? b_addr  : a_addr;
  assign pick_din  = grant_b ? b_wdata : a_wdata;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      clr_pending_q <= 1'b0;
      last_b_q      <= 1'b1;
      sel_b_q       <= 1'b0;
      txn_we_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      clr_pending_q <= clr_pending_d;
      last_b_q      <= last_b_d;
      sel_b_q       <= sel_b_d;
      txn_we_q      <= txn_we_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
    end
  end

  // Next-state logic
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    clr_pending_d = clr_pending_q | clr_start;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d       = S_CLEAR;
          clr_pending_d = 1'b0;
        end else if (a_req | b_req) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_CLEAR: begin
        // The RAM address register doubles as the clear counter.
        if (ram_addr_q == LAST_ADDR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic: computes the registered outputs for the next cycle
  always_comb begin
    last_b_d   = last_b_q;
    sel_b_d    = sel_b_q;
    txn_we_d   = txn_we_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          ram_we_d   = 1'b1;
          ram_addr_d = '0;
          ram_din_d  = CLR_VALUE;
        end else if (grant_a | grant_b) begin
          sel_b_d    = grant_b;
          last_b_d   = grant_b;
          txn_we_d   = pick_we;
          ram_we_d   = pick_we;
          ram_addr_d = pick_addr;
          ram_din_d  = pick_din;
        end
      end
      S_RESP: begin
        // ram_dout holds the word registered by the RAM at the ISSUE edge.
        a_ack_d = ~sel_b_q;
        b_ack_d = sel_b_q;
        if (!txn_we_q) begin
          if (sel_b_q) b_rdata_d = ram_dout;
          else         a_rdata_d = ram_dout;
        end
      end
      S_CLEAR: begin
        if (ram_addr_q != LAST_ADDR) begin
          ram_we_d   = 1'b1;
          ram_addr_d = ram_addr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_rr_arbiter
//
// Directed bench for ram_rr_arbiter with an external RAM model. A
// transaction-level reference expands each grant or clear into its per-cycle
// output waveform; a compare process checks every DUT output against it on
// each negedge. Directed literal checks pin the expected sequences.
// -----------------------------------------------------------------------------
module tb_ram_rr_arbiter;

  localparam int            AW    = 3;
  localparam int            DW    = 8;
  localparam int            DEPTH = 1 << AW;
  localparam logic [DW-1:0] CLR   = 8'h00;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          a_req     = 1'b0;
  logic          a_we      = 1'b0;
  logic [AW-1:0] a_addr    = '0;
  logic [DW-1:0] a_wdata   = '0;
  logic          b_req     = 1'b0;
  logic          b_we      = 1'b0;
  logic [AW-1:0] b_addr    = '0;
  logic [DW-1:0] b_wdata   = '0;
  logic          clr_start = 1'b0;
  logic          a_ack, b_ack, busy, ram_we;
  logic [DW-1:0] a_rdata, b_rdata, ram_din;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_rr_arbiter #(.AW(AW), .DW(DW), .CLR_VALUE(CLR)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .b_rdata  (b_rdata),
    .clr_start(clr_start),
    .busy     (busy),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // External single-port RAM: write when we=1, registered read otherwise.
  logic [DW-1:0] ram_mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one expected output snapshot per cycle. A grant expands to
  // three snapshots (issue, wait, ack), a clear to DEPTH write snapshots plus
  // one idle snapshot; the arbiter decides again only once its plan is empty.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          busy;
    logic          a_ack;
    logic          b_ack;
    logic [DW-1:0] a_rdata;
    logic [DW-1:0] b_rdata;
  } obs_t;

  obs_t          exp_o = '0;
  obs_t          plan[$];
  logic [DW-1:0] m_mem [DEPTH] = '{default: '0};
  bit            m_last_b = 1'b1;
  bit            m_pend   = 1'b0;
  int            cyc      = 0;

  always @(posedge clk) begin : model
    obs_t          idle_o;
    obs_t          e;
    logic          pick_b;
    logic          t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_din;
    cyc++;
    // The RAM commits whatever write was on its pins during the last cycle.
    if (exp_o.we) m_mem[exp_o.addr] = exp_o.din;
    idle_o       = exp_o;
    idle_o.we    = 1'b0;
    idle_o.busy  = 1'b0;
    idle_o.a_ack = 1'b0;
    idle_o.b_ack = 1'b0;
    if (rst) begin
      plan.delete();
      exp_o    = '0;
      m_last_b = 1'b1;
      m_pend   = 1'b0;
    end else begin
      if (clr_start) m_pend = 1'b1;
      if (plan.size() == 0) begin
        if (m_pend) begin
          m_pend = 1'b0;
          for (int k = 0; k < DEPTH; k++) begin
            e = idle_o; e.we = 1'b1; e.busy = 1'b1; e.addr = AW'(k); e.din = CLR;
            plan.push_back(e);
          end
          e = idle_o; e.addr = AW'(DEPTH - 1); e.din = CLR;
          plan.push_back(e);
        end else if (a_req || b_req) begin
          pick_b   = b_req && (!a_req || !m_last_b);
          m_last_b = pick_b;
          t_we     = pick_b ? b_we    : a_we;
          t_addr   = pick_b ? b_addr  : a_addr;
          t_din    = pick_b ? b_wdata : a_wdata;
          e = idle_o; e.we = t_we; e.addr = t_addr; e.din = t_din; e.busy = 1'b1;
          plan.push_back(e);
          e.we = 1'b0;
          plan.push_back(e);
          e.busy = 1'b0;
          if (pick_b) e.b_ack = 1'b1; else e.a_ack = 1'b1;
          if (!t_we) begin
            if (pick_b) e.b_rdata = m_mem[t_addr]; else e.a_rdata = m_mem[t_addr];
          end
          plan.push_back(e);
        end
      end
      exp_o = (plan.size() != 0) ? plan.pop_front() : idle_o;
    end
  end

  always @(negedge clk) begin : compare
    if (cyc > 0) begin
      check("ram_we",   32'(ram_we),        32'(exp_o.we));
      check("ram_addr", 32'(ram_addr),      32'(exp_o.addr));
      check("ram_din",  32'(ram_din),       32'(exp_o.din));
      check("busy",     32'(busy),          32'(exp_o.busy));
      check("a_ack",    32'(a_ack),         32'(exp_o.a_ack));
      check("b_ack",    32'(b_ack),         32'(exp_o.b_ack));
      check("a_rdata",  32'(a_rdata),       32'(exp_o.a_rdata));
      check("b_rdata",  32'(b_rdata),       32'(exp_o.b_rdata));
      check("ack_excl", 32'(a_ack & b_ack), 32'(0));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic          iss_we;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_din;

  // Called right after a negedge with the arbiter idle. Returns the number of
  // negedges until the ack (0 on timeout) and the rdata seen with the ack.
  task automatic txn(input bit use_b, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rd);
    if (use_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else       begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    lat = 0;
    rd  = '0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 1) begin iss_we = ram_we; iss_addr = ram_addr; iss_din = ram_din; end
      if (use_b ? b_ack : a_ack) begin
        lat = t;
        rd  = use_b ? b_rdata : a_rdata;
        break;
      end
    end
    if (use_b) b_req = 1'b0; else a_req = 1'b0;
  endtask

  initial begin : stim
    int            lat;
    logic [DW-1:0] rd;
    int            seq [4];
    int            at [4];
    logic [DW-1:0] rdv [4];
    int            bt [3];
    int            n, na, nb, cnt_a, cnt_b, cnt_we;
    bit            both;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ram_we",   32'(ram_we),   0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_busy",     32'(busy),     0);
    check("rst_a_rdata",  32'(a_rdata),  0);
    rst = 1'b0;

    // A writes 5A to address 3, then reads it back
    txn(1'b0, 1'b1, 3'd3, 8'h5A, lat, rd);
    check("t1_wr_lat",   lat,              3);
    check("t1_iss_we",   32'(iss_we),      1);
    check("t1_iss_addr", 32'(iss_addr),    3);
    check("t1_iss_din",  32'(iss_din),     32'h5A);
    txn(1'b0, 1'b0, 3'd3, 8'h00, lat, rd);
    check("t1_rd_lat",   lat,              3);
    check("t1_rd_data",  32'(rd),          32'h5A);
    check("t1_rd_we",    32'(iss_we),      0);

    // Simultaneous requests from reset: grants alternate A, B, A, B
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd1; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b1; b_addr = 3'd2; b_wdata = 8'h22;
    foreach (seq[i]) begin seq[i] = -1; at[i] = -1; rdv[i] = '0; end
    n = 0; na = 0; nb = 0; both = 1'b0;
    for (int t = 1; t <= 40 && n < 4; t++) begin
      @(negedge clk);
      if (a_ack && b_ack) both = 1'b1;
      if (a_ack) begin
        seq[n] = 0; at[n] = t; rdv[n] = a_rdata; n++; na++;
        if (na == 1) begin a_we = 1'b0; a_addr = 3'd2; end else a_req = 1'b0;
      end else if (b_ack) begin
        seq[n] = 1; at[n] = t; rdv[n] = b_rdata; n++; nb++;
        if (nb == 1) begin b_we = 1'b0; b_addr = 3'd1; end else b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("t2_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_order", seq[i], i % 2);
      check("t2_time",  at[i],  3 * (i + 1));
    end
    check("t2_a_rdata", 32'(rdv[2]), 32'h22);
    check("t2_b_rdata", 32'(rdv[3]), 32'h11);
    check("t2_both",    32'(both),   0);

    // B alone, req held: ack every 3 cycles, A never acked
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd2;
    cnt_a = 0; cnt_b = 0; rd = '0;
    foreach (bt[i]) bt[i] = -1;
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      if (a_ack) cnt_a++;
      if (b_ack) begin
        if (cnt_b < 3) bt[cnt_b] = t;
        cnt_b++;
        rd = b_rdata;
        if (cnt_b == 3) b_req = 1'b0;
      end
    end
    b_req = 1'b0;
    check("t3_b_count", cnt_b, 3);
    for (int i = 0; i < 3; i++) check("t3_b_time", bt[i], 3 * (i + 1));
    check("t3_a_count", cnt_a, 0);
    check("t3_b_rdata", 32'(rd), 32'h22);

    // Clear from idle: 8 consecutive writes of CLR to 0..7
    txn(1'b0, 1'b1, 3'd7, 8'hE7, lat, rd);
    check("t4_wr_lat", lat, 3);
    clr_start = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      clr_start = 1'b0;
      check("t4_we",   32'(ram_we),   1);
      check("t4_addr", 32'(ram_addr), k);
      check("t4_din",  32'(ram_din),  32'(CLR));
      check("t4_busy", 32'(busy),     1);
    end
    @(negedge clk);
    check("t4_end_we",   32'(ram_we), 0);
    check("t4_end_busy", 32'(busy),   0);
    txn(1'b0, 1'b0, 3'd7, 8'h00, lat, rd);
    check("t4_rd_lat",  lat,     3);
    check("t4_rd_data", 32'(rd), 32'(CLR));

    // Clear pulsed during an A read's ISSUE cycle; B waits out the clear
    txn(1'b0, 1'b1, 3'd5, 8'hC3, lat, rd);
    check("t5_wr_lat", lat, 3);
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd5;
    @(negedge clk);
    check("t5_issue_addr", 32'(ram_addr), 5);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    @(negedge clk);
    check("t5_a_ack",   32'(a_ack),   1);
    check("t5_a_rdata", 32'(a_rdata), 32'hC3);
    a_req = 1'b0;
    @(negedge clk);
    check("t5_clr_we",   32'(ram_we),   1);
    check("t5_clr_addr", 32'(ram_addr), 0);
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd5;
    lat = 0; rd = '1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (b_ack) begin lat = t; rd = b_rdata; break; end
    end
    b_req = 1'b0;
    check("t5_b_lat",   lat,     10);
    check("t5_b_rdata", 32'(rd), 32'(CLR));

    // Reset in CLEAR at counter 4 abandons the clear
    txn(1'b0, 1'b1, 3'd6, 8'h77, lat, rd);
    txn(1'b0, 1'b1, 3'd2, 8'h99, lat, rd);
    clr_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clr_start = 1'b0;
    end
    check("t6_at4", 32'(ram_addr), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_we",      32'(ram_we),   0);
    check("t6_rst_addr",    32'(ram_addr), 0);
    check("t6_rst_busy",    32'(busy),     0);
    check("t6_rst_a_rdata", 32'(a_rdata),  0);
    cnt_we = 0; cnt_a = 0; cnt_b = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (ram_we) cnt_we++;
      if (a_ack || b_ack) cnt_a++;
      if (busy) cnt_b++;
    end
    check("t6_no_we",   cnt_we, 0);
    check("t6_no_ack",  cnt_a,  0);
    check("t6_no_busy", cnt_b,  0);
    txn(1'b0, 1'b0, 3'd6, 8'h00, lat, rd);
    check("t6_rd6", 32'(rd), 32'h77);
    txn(1'b1, 1'b0, 3'd2, 8'h00, lat, rd);
    check("t6_rd2", 32'(rd), 32'(CLR));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
